// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct fields and ALU operation codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_ILEGAL    = 4'd12
    } estado_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // States whose exit back to FETCH completes (retires) an instruction.
    function automatic logic retira(input estado_t s);
        return (s == S_MEM_WB) || (s == S_MEM_WRITE) || (s == S_R_WB) ||
               (s == S_I_WB)   || (s == S_BRANCH)    || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/control_alu.sv
// ALU operation decode: funct field for R-type, opcode for immediate forms.
module control_alu
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       valido_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valido_o   = 1'b1;
        if (opcode_i == OP_RTYPE) begin
            case (funct_i)
                FN_ADD:  alu_ctrl_o = ALU_ADD;
                FN_SUB:  alu_ctrl_o = ALU_SUB;
                FN_AND:  alu_ctrl_o = ALU_AND;
                FN_OR:   alu_ctrl_o = ALU_OR;
                FN_XOR:  alu_ctrl_o = ALU_XOR;
                FN_NOR:  alu_ctrl_o = ALU_NOR;
                FN_SLT:  alu_ctrl_o = ALU_SLT;
                default: valido_o   = 1'b0;
            endcase
        end else begin
            case (opcode_i)
                OP_ADDI: alu_ctrl_o = ALU_ADD;
                OP_ANDI: alu_ctrl_o = ALU_AND;
                OP_ORI:  alu_ctrl_o = ALU_OR;
                OP_SLTI: alu_ctrl_o = ALU_SLT;
                default: valido_o   = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS control FSM: state register, datapath control decode
// and retired-instruction counter.
module control_multiciclo
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        cero,
    output logic [3:0]  controlALU,
    output logic        escribirPC,
    output logic        escribirIR,
    output logic        leerMem,
    output logic        escribirMem,
    output logic        escribirReg,
    output logic        iOrD,
    output logic        selA,
    output logic [1:0]  selB,
    output logic [1:0]  fuentePC,
    output logic        regDst,
    output logic        memAReg,
    output logic [3:0]  estado,
    output logic        excepcion,
    output logic [31:0] instrRetiradas
);

    estado_t     estado_q, estado_d;
    logic [31:0] retirada_q;
    logic [3:0]  alu_dec;
    logic        alu_valido;

    logic wpc, wir, rmem, wmem, wreg, exc;

    control_alu u_control_alu (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_ctrl_o (alu_dec),
        .valido_o   (alu_valido)
    );

    always_comb begin
        estado_d = S_FETCH;
        case (estado_q)
            S_FETCH:  estado_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                       estado_d = S_MEM_ADDR;
                    OP_RTYPE:                           estado_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  estado_d = S_EXEC_I;
                    OP_BEQ:                             estado_d = S_BRANCH;
                    OP_J:                               estado_d = S_JUMP;
                    default:                            estado_d = S_ILEGAL;
                endcase
            end
            S_MEM_ADDR: estado_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: estado_d = S_MEM_WB;
            S_EXEC_R:   estado_d = alu_valido ? S_R_WB : S_ILEGAL;
            S_EXEC_I:   estado_d = S_I_WB;
            default:    estado_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= S_FETCH;
            retirada_q <= 32'd0;
        end else begin
            estado_q <= estado_d;
            if (retira(estado_q))
                retirada_q <= retirada_q + 32'd1;
        end
    end

    // Outputs decode straight from the state so FETCH is live on the very
    // first cycle after reset; enables are gated by rst_n so an abort
    // cancels a pending write without waiting for a clock edge.
    always_comb begin
        wpc        = 1'b0;
        wir        = 1'b0;
        rmem       = 1'b0;
        wmem       = 1'b0;
        wreg       = 1'b0;
        exc        = 1'b0;
        iOrD       = 1'b0;
        selA       = 1'b0;
        selB       = 2'b00;
        fuentePC   = 2'b00;
        regDst     = 1'b0;
        memAReg    = 1'b0;
        controlALU = ALU_AND;
        case (estado_q)
            S_FETCH: begin
                rmem       = 1'b1;
                wir        = 1'b1;
                wpc        = 1'b1;
                selB       = 2'b01;
                controlALU = ALU_ADD;
            end
            S_DECODE: begin
                selB       = 2'b11;
                controlALU = ALU_ADD;
            end
            S_MEM_ADDR: begin
                selA       = 1'b1;
                selB       = 2'b10;
                controlALU = ALU_ADD;
            end
            S_MEM_READ: begin
                iOrD = 1'b1;
                rmem = 1'b1;
            end
            S_MEM_WB: begin
                wreg    = 1'b1;
                memAReg = 1'b1;
            end
            S_MEM_WRITE: begin
                iOrD = 1'b1;
                wmem = 1'b1;
            end
            S_EXEC_R: begin
                selA       = 1'b1;
                controlALU = alu_dec;
            end
            S_R_WB: begin
                wreg   = 1'b1;
                regDst = 1'b1;
            end
            S_EXEC_I: begin
                selA       = 1'b1;
                selB       = 2'b10;
                controlALU = alu_dec;
            end
            S_I_WB: wreg = 1'b1;
            S_BRANCH: begin
                selA       = 1'b1;
                controlALU = ALU_SUB;
                fuentePC   = 2'b01;
                wpc        = cero;
            end
            S_JUMP: begin
                fuentePC = 2'b10;
                wpc      = 1'b1;
            end
            S_ILEGAL: exc = 1'b1;
            default: ;
        endcase
    end

    assign escribirPC     = wpc  & rst_n;
    assign escribirIR     = wir  & rst_n;
    assign leerMem        = rmem & rst_n;
    assign escribirMem    = wmem & rst_n;
    assign escribirReg    = wreg & rst_n;
    assign excepcion      = exc  & rst_n;
    assign estado         = estado_q;
    assign instrRetiradas = retirada_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed test of the multicycle control FSM with hand-computed expectations.
module tb_control_multiciclo;

    logic        clk, rst_n, cero;
    logic [5:0]  opcode, funct;
    logic [3:0]  controlALU, estado;
    logic        escribirPC, escribirIR, leerMem, escribirMem, escribirReg;
    logic        iOrD, selA, regDst, memAReg, excepcion;
    logic [1:0]  selB, fuentePC;
    logic [31:0] instrRetiradas;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_cnt;

    control_multiciclo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode         (opcode),
        .funct          (funct),
        .cero           (cero),
        .controlALU     (controlALU),
        .escribirPC     (escribirPC),
        .escribirIR     (escribirIR),
        .leerMem        (leerMem),
        .escribirMem    (escribirMem),
        .escribirReg    (escribirReg),
        .iOrD           (iOrD),
        .selA           (selA),
        .selB           (selB),
        .fuentePC       (fuentePC),
        .regDst         (regDst),
        .memAReg        (memAReg),
        .estado         (estado),
        .excepcion      (excepcion),
        .instrRetiradas (instrRetiradas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic ciclo();
        @(negedge clk);
    endtask

    // {escribirPC, escribirIR, leerMem, escribirMem, escribirReg}
    function automatic logic [4:0] en();
        return {escribirPC, escribirIR, leerMem, escribirMem, escribirReg};
    endfunction

    // Called at a negedge in FETCH; leaves the bench at the next FETCH negedge.
    task automatic run_r(input logic [5:0] fn, input logic [3:0] exp_alu, input string tag);
        opcode = 6'b000000;
        funct  = fn;
        ciclo();
        ciclo();
        chk({tag, "_exec_state"}, estado, 32'd6);
        chk({tag, "_alu"}, controlALU, exp_alu);
        ciclo();
        chk({tag, "_wb_en"}, en(), 5'b00001);
        ciclo();
        exp_cnt = exp_cnt + 1;
        chk({tag, "_cnt"}, instrRetiradas, exp_cnt);
    endtask

    task automatic run_i(input logic [5:0] op, input logic [3:0] exp_alu, input string tag);
        opcode = op;
        ciclo();
        ciclo();
        chk({tag, "_exec_state"}, estado, 32'd8);
        chk({tag, "_alu"}, controlALU, exp_alu);
        chk({tag, "_selB"}, selB, 2'b10);
        ciclo();
        chk({tag, "_wb_state"}, estado, 32'd9);
        chk({tag, "_wb_sel"}, {en(), regDst, memAReg}, 7'b0000100);
        ciclo();
        exp_cnt = exp_cnt + 1;
        chk({tag, "_cnt"}, instrRetiradas, exp_cnt);
    endtask

    logic [5:0] r_fn  [6] = '{6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    logic [3:0] r_alu [6] = '{4'b0110,   4'b0000,   4'b0001,   4'b0011,   4'b1100,   4'b0111};

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b000000;
        funct  = 6'b000000;
        cero   = 1'b0;
        exp_cnt = 32'd0;
        repeat (2) ciclo();
        chk("rst_state", estado, 32'd0);
        chk("rst_cnt", instrRetiradas, 32'd0);
        chk("rst_exc", excepcion, 1'b0);
        chk("rst_en", en(), 5'b00000);

        // add: FETCH, DECODE, EXEC_R, R_WB
        funct = 6'b100000;
        rst_n = 1'b1;
        #1;
        chk("fetch_en", en(), 5'b11100);
        chk("fetch_sel", {selA, selB, fuentePC, controlALU}, {1'b0, 2'b01, 2'b00, 4'b0010});
        ciclo();
        chk("decode_state", estado, 32'd1);
        chk("decode_sel", {selA, selB, en()}, {1'b0, 2'b11, 5'b00000});
        ciclo();
        chk("add_exec_state", estado, 32'd6);
        chk("add_exec_sel", {selA, selB, controlALU}, {1'b1, 2'b00, 4'b0010});
        ciclo();
        chk("add_wb_state", estado, 32'd7);
        chk("add_wb", {en(), regDst, memAReg}, 7'b0000110);
        ciclo();
        exp_cnt = 32'd1;
        chk("add_cnt", instrRetiradas, exp_cnt);
        chk("add_back_fetch", estado, 32'd0);

        for (int i = 0; i < 6; i++) run_r(r_fn[i], r_alu[i], $sformatf("rfn%0d", i));

        // lw: 5 cycles
        opcode = 6'b100011;
        ciclo();
        ciclo();
        chk("lw_addr", {estado, selA, selB, controlALU, en()}, {4'd2, 1'b1, 2'b10, 4'b0010, 5'b00000});
        ciclo();
        chk("lw_read", {estado, iOrD, en()}, {4'd3, 1'b1, 5'b00100});
        ciclo();
        chk("lw_wb", {estado, en(), regDst, memAReg}, {4'd4, 5'b00001, 1'b0, 1'b1});
        ciclo();
        exp_cnt = exp_cnt + 1;
        chk("lw_fetch", estado, 32'd0);
        chk("lw_cnt", instrRetiradas, exp_cnt);

        run_i(6'b001000, 4'b0010, "addi");
        run_i(6'b001100, 4'b0000, "andi");
        run_i(6'b001101, 4'b0001, "ori");
        run_i(6'b001010, 4'b0111, "slti");

        // beq taken, then cero toggled inside BRANCH (Mealy path)
        opcode = 6'b000100;
        cero   = 1'b1;
        ciclo();
        ciclo();
        chk("beq1_state", estado, 32'd10);
        chk("beq1_pc", {escribirPC, fuentePC, controlALU, selA, selB}, {1'b1, 2'b01, 4'b0110, 1'b1, 2'b00});
        cero = 1'b0;
        #1;
        chk("beq_mealy", escribirPC, 1'b0);
        ciclo();
        exp_cnt = exp_cnt + 1;
        chk("beq1_cnt", instrRetiradas, exp_cnt);
        ciclo();
        ciclo();
        chk("beq0_pc", {estado, en(), fuentePC}, {4'd10, 5'b00000, 2'b01});
        ciclo();
        exp_cnt = exp_cnt + 1;
        chk("beq0_cnt", instrRetiradas, exp_cnt);

        // illegal opcode
        opcode = 6'b111111;
        ciclo();
        ciclo();
        chk("ilop_state", estado, 32'd12);
        chk("ilop_exc", {excepcion, en()}, 6'b100000);
        ciclo();
        chk("ilop_back", {estado, excepcion}, {4'd0, 1'b0});
        chk("ilop_cnt", instrRetiradas, exp_cnt);

        // illegal funct
        opcode = 6'b000000;
        funct  = 6'b000001;
        ciclo();
        ciclo();
        chk("ilfn_exec", {estado, en()}, {4'd6, 5'b00000});
        ciclo();
        chk("ilfn_exc", {estado, excepcion, en()}, {4'd12, 1'b1, 5'b00000});
        ciclo();
        chk("ilfn_back", {estado, excepcion}, {4'd0, 1'b0});
        chk("ilfn_cnt", instrRetiradas, exp_cnt);

        // sw aborted by reset in MEM_WRITE
        opcode = 6'b101011;
        ciclo();
        ciclo();
        ciclo();
        chk("sw_write", {estado, iOrD, en()}, {4'd5, 1'b1, 5'b00010});
        #2 rst_n = 1'b0;
        #1;
        chk("sw_abort_wmem", escribirMem, 1'b0);
        chk("sw_abort_state", estado, 32'd0);
        ciclo();
        rst_n = 1'b1;
        #1;
        exp_cnt = 32'd0;
        chk("post_rst_state", estado, 32'd0);
        chk("post_rst_cnt", instrRetiradas, exp_cnt);

        // j with counter preloaded to all ones
        opcode = 6'b000010;
        force dut.retirada_q = 32'hFFFF_FFFF;
        ciclo();
        release dut.retirada_q;
        chk("j_preload", instrRetiradas, 32'hFFFF_FFFF);
        ciclo();
        chk("j_state", {estado, fuentePC, en()}, {4'd11, 2'b10, 5'b10000});
        ciclo();
        chk("j_wrap", instrRetiradas, 32'd0);
        chk("j_fetch", estado, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
